// File: rtl/multiport_register_file_pkg.sv
// Core register-file types shared by the register file and writeback logic.
// Widths here describe the default core configuration (32 x 32-bit).
package multiport_register_file_pkg;
  localparam int CORE_DATA_W = 32;
  localparam int CORE_REGS   = 32;
  localparam int CORE_ADDR_W = $clog2(CORE_REGS);

  typedef logic [CORE_ADDR_W-1:0] reg_addr_t;
  typedef logic [CORE_DATA_W-1:0] reg_data_t;

  // One writeback lane as it travels from the execute units.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } wb_port_t;
endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy bits for RAW hazard detection: issue sets, writeback
// clears, issue wins over a same-cycle writeback. Count tracks the bits.
module multiport_register_file_scoreboard #(
  parameter int REG_COUNT   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter bit ZERO_REG    = 1'b1,
  parameter bit BYPASS      = 1'b1,
  localparam int ADDR_W = $clog2(REG_COUNT),
  localparam int CNT_W  = $clog2(REG_COUNT + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                issue_en,
  input  logic [ADDR_W-1:0]                   issue_addr,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]   rd_addr,
  output logic [READ_PORTS-1:0]               rd_busy,
  output logic [REG_COUNT-1:0]                busy_vector,
  output logic [CNT_W-1:0]                    busy_count
);
  logic [REG_COUNT-1:0] busy_d, busy_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      for (int p = 0; p < WRITE_PORTS; p++)
        if (wr_en[p] && wr_addr[p] == ADDR_W'(r)) busy_d[r] = 1'b0;
      if (issue_en && issue_addr == ADDR_W'(r)) busy_d[r] = 1'b1;
      if (ZERO_REG && r == 0) busy_d[r] = 1'b0;
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A same-cycle writeback resolves the hazard unless a newer producer issues.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_busy[i] = busy_q[rd_addr[i]];
      if (BYPASS) begin
        for (int p = 0; p < WRITE_PORTS; p++)
          if (wr_en[p] && wr_addr[p] == rd_addr[i] &&
              !(issue_en && issue_addr == rd_addr[i]))
            rd_busy[i] = 1'b0;
      end
    end
  end

  assign busy_vector = busy_q;
  assign busy_count  = cnt_q;
endmodule

// File: rtl/multiport_register_file.sv
// Multi-read, multi-write register file with optional write-to-read bypass
// and a busy scoreboard for hazard detection.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = CORE_DATA_W,
  parameter int REG_COUNT   = CORE_REGS,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter bit ZERO_REG    = 1'b1,
  parameter bit BYPASS      = 1'b1,
  localparam int ADDR_W = $clog2(REG_COUNT),
  localparam int CNT_W  = $clog2(REG_COUNT + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]      rd_addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]                  rd_busy,
  input  logic [WRITE_PORTS-1:0]                 wr_en,
  input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]     wr_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                   issue_en,
  input  logic [ADDR_W-1:0]                      issue_addr,
  output logic [REG_COUNT-1:0]                   busy_vector,
  output logic [CNT_W-1:0]                       busy_count,
  input  logic [ADDR_W-1:0]                      dbg_addr,
  output logic [DATA_WIDTH-1:0]                  dbg_data
);
  typedef struct packed {
    logic                  en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_port_t;

  wr_port_t [WRITE_PORTS-1:0] wp;
  logic [DATA_WIDTH-1:0] mem_d [REG_COUNT];
  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

  // Writes to the hard-wired zero register are dropped at the source, so
  // both the storage and the bypass path see only effective writes.
  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wp[p].en   = wr_en[p] && !(ZERO_REG && wr_addr[p] == '0);
      wp[p].addr = wr_addr[p];
      wp[p].data = wr_data[p];
    end
  end

  // Ascending port order: the highest-index port lands last and wins.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < WRITE_PORTS; p++)
      if (wp[p].en) mem_d[wp[p].addr] = wp[p].data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_data[i] = mem_q[rd_addr[i]];
      if (BYPASS) begin
        for (int p = 0; p < WRITE_PORTS; p++)
          if (wp[p].en && wp[p].addr == rd_addr[i]) rd_data[i] = wp[p].data;
      end
      if (reset || (ZERO_REG && rd_addr[i] == '0)) rd_data[i] = '0;
    end
  end

  always_comb begin
    dbg_data = mem_q[dbg_addr];
    if (reset || (ZERO_REG && dbg_addr == '0)) dbg_data = '0;
  end

  multiport_register_file_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .READ_PORTS (READ_PORTS),
    .WRITE_PORTS(WRITE_PORTS),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_sb (
    .clock      (clock),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .busy_vector(busy_vector),
    .busy_count (busy_count)
  );
endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: directed table, async reset sequence,
// and randomized traffic against a reference model (bypass and no-bypass).
module tb_multiport_register_file;
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0][4:0]  rd_addr = '0;
  logic [1:0]       wr_en = '0;
  logic [1:0][4:0]  wr_addr = '0;
  logic [1:0][31:0] wr_data = '0;
  logic             issue_en = 1'b0;
  logic [4:0]       issue_addr = '0;
  logic [4:0]       dbg_addr = '0;

  logic [1:0][31:0] rd_data_b, rd_data_n;
  logic [1:0]       rd_busy_b, rd_busy_n;
  logic [31:0]      bv_b, bv_n;
  logic [5:0]       cnt_b, cnt_n;
  logic [31:0]      dbg_b, dbg_n;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  multiport_register_file #(.BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vector(bv_b),
    .busy_count(cnt_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  multiport_register_file #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vector(bv_n),
    .busy_count(cnt_n), .dbg_addr(dbg_addr), .dbg_data(dbg_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra;
    logic [31:0] exp_rd;   // bypass build, same cycle
    logic        exp_bsy;  // bypass build rd_busy, same cycle
    logic [31:0] exp_nb;   // no-bypass build / storage, same cycle
    logic [5:0]  exp_cnt;  // after the edge
  } vec_t;

  // Reference model state
  logic [31:0] m_mem [32];
  logic        m_busy [32];

  task automatic drive(input vec_t v);
    wr_en = v.we; wr_addr[0] = v.wa0; wr_addr[1] = v.wa1;
    wr_data[0] = v.wd0; wr_data[1] = v.wd1;
    issue_en = v.ie; issue_addr = v.ia;
    rd_addr[0] = v.ra; rd_addr[1] = v.ra; dbg_addr = v.ra;
  endtask

  task automatic idle(input logic [4:0] ra);
    vec_t v;
    v = '{we: 2'b00, wa0: 5'd0, wa1: 5'd0, wd0: 32'd0, wd1: 32'd0, ie: 1'b0,
          ia: 5'd0, ra: ra, exp_rd: 32'd0, exp_bsy: 1'b0, exp_nb: 32'd0, exp_cnt: 6'd0};
    drive(v);
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] ra, input bit byp);
    logic [31:0] v;
    v = m_mem[ra];
    if (byp)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p] == ra) v = wr_data[p];
    if (ra == 5'd0) v = 32'd0;
    return v;
  endfunction

  function automatic logic model_busy(input logic [4:0] ra, input bit byp);
    logic b;
    logic wr_hit;
    b = m_busy[ra];
    wr_hit = (wr_en[0] && wr_addr[0] == ra) || (wr_en[1] && wr_addr[1] == ra);
    if (byp && wr_hit && !(issue_en && issue_addr == ra)) b = 1'b0;
    return b;
  endfunction

  task automatic model_step();
    logic        nb [32];
    for (int r = 0; r < 32; r++) begin
      logic wr_hit;
      wr_hit = (wr_en[0] && wr_addr[0] == 5'(r)) || (wr_en[1] && wr_addr[1] == 5'(r));
      if (issue_en && issue_addr == 5'(r)) nb[r] = 1'b1;
      else if (wr_hit)                     nb[r] = 1'b0;
      else                                 nb[r] = m_busy[r];
    end
    nb[0] = 1'b0;
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] != 5'd0) m_mem[wr_addr[p]] = wr_data[p];
    for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
  endtask

  function automatic logic [31:0] model_bv();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{2'b11, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0, 32'h0, 6'd0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0, 32'h22222222, 6'd0};
    tbl[2]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h0, 1'b0, 32'h0, 6'd1};
    tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h0, 1'b1, 32'h0, 6'd1};
    tbl[5]  = '{2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd3, 32'hA5A5A5A5, 1'b0, 32'h0, 6'd0};
    tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 6'd0};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 32'h0, 1'b0, 32'h0, 6'd1};
    tbl[8]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h00000099, 1'b1, 5'd9, 5'd9, 32'h00000099, 1'b1, 32'h0, 6'd1};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h00000099, 1'b1, 32'h00000099, 6'd1};
    tbl[10] = '{2'b01, 5'd4, 5'd0, 32'h00001234, 32'h0, 1'b0, 5'd0, 5'd4, 32'h00001234, 1'b0, 32'h0, 6'd1};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 32'h00001234, 1'b0, 32'h00001234, 6'd1};
    tbl[12] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 6'd1};

    // Reset state
    #2;
    chk("reset_rd0", rd_data_b[0], 32'h0);
    chk("reset_cnt", 32'(cnt_b), 32'h0);
    chk("reset_bv", bv_b, 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("t%0d_rd_byp", i), rd_data_b[0], tbl[i].exp_rd);
      chk($sformatf("t%0d_rd1_byp", i), rd_data_b[1], tbl[i].exp_rd);
      chk($sformatf("t%0d_busy_byp", i), 32'(rd_busy_b[0]), 32'(tbl[i].exp_bsy));
      chk($sformatf("t%0d_rd_nb", i), rd_data_n[0], tbl[i].exp_nb);
      chk($sformatf("t%0d_dbg", i), dbg_b, tbl[i].exp_nb);
      @(posedge clock); #1;
      chk($sformatf("t%0d_cnt", i), 32'(cnt_b), 32'(tbl[i].exp_cnt));
      chk($sformatf("t%0d_cnt_nb", i), 32'(cnt_n), 32'(tbl[i].exp_cnt));
      chk($sformatf("t%0d_bv0", i), 32'(bv_b[0]), 32'h0);
    end
    chk("r9_still_busy", 32'(bv_b[9]), 32'h1);

    // Async reset mid-cycle after r5 holds DEADBEEF
    idle(5'd5);
    #2 chk("r5_before_rst", rd_data_b[0], 32'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_rd", rd_data_b[0], 32'h0);
    chk("async_rst_dbg", dbg_n, 32'h0);
    chk("async_rst_cnt", 32'(cnt_b), 32'h0);
    chk("async_rst_bv", bv_b, 32'h0);
    // Write and issue while reset is held must be discarded
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h66666666;
    issue_en = 1'b1; issue_addr = 5'd6; rd_addr[0] = 5'd6;
    #1 chk("rst_held_rd", rd_data_b[0], 32'h0);
    chk("rst_held_busy", 32'(rd_busy_b[0]), 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    idle(5'd6);
    #1;
    chk("rst_drop_rd", rd_data_n[0], 32'h0);
    chk("rst_drop_busy", 32'(bv_b[6]), 32'h0);
    chk("rst_drop_cnt", 32'(cnt_b), 32'h0);

    // Randomized traffic vs reference model, starting from the reset state
    for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) != 0);
        wr_addr[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wr_data[p] = $urandom;
        rd_addr[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      end
      issue_en   = ($urandom_range(0, 1) == 0);
      issue_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      #3;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rnd%0d_rd%0d_byp", c, i), rd_data_b[i], model_rd(rd_addr[i], 1'b1));
        chk($sformatf("rnd%0d_rd%0d_nb", c, i), rd_data_n[i], model_rd(rd_addr[i], 1'b0));
        chk($sformatf("rnd%0d_busy%0d_byp", c, i), 32'(rd_busy_b[i]), 32'(model_busy(rd_addr[i], 1'b1)));
        chk($sformatf("rnd%0d_busy%0d_nb", c, i), 32'(rd_busy_n[i]), 32'(model_busy(rd_addr[i], 1'b0)));
      end
      chk($sformatf("rnd%0d_dbg", c), dbg_b, (dbg_addr == 5'd0) ? 32'h0 : m_mem[dbg_addr]);
      model_step();
      @(posedge clock); #1;
      chk($sformatf("rnd%0d_bv", c), bv_b, model_bv());
      chk($sformatf("rnd%0d_cnt", c), 32'(cnt_b), 32'($countones(model_bv())));
      chk($sformatf("rnd%0d_cnt_nb", c), 32'(cnt_n), 32'($countones(model_bv())));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
